// File: rtl/hqm_rcfwl_gclk_refclkdist_pkg.sv
// Shared types and constants for the programmable reference-clock distributor.
package hqm_rcfwl_gclk_refclkdist_pkg;

  localparam int RATIO_W   = 4;
  localparam int MIN_RATIO = 2;
  localparam int DEF_RATIO = 4;

  typedef logic [RATIO_W-1:0] ratio_t;

endpackage

// File: rtl/hqm_rcfwl_gclk_chdiv.sv
// One divided-clock channel: shadowed ratio/enable, period counter, 50% duty output.
module hqm_rcfwl_gclk_chdiv #(
  parameter int DIVW      = 4,
  parameter int RST_RATIO = 4
) (
  input  logic            x4clk_in,
  input  logic            rst_b,
  input  logic            sync_rise,
  input  logic            ch_en,
  input  logic [DIVW-1:0] ch_ratio,
  output logic            ch_clk_out,
  output logic            ch_sync_out
);
  import hqm_rcfwl_gclk_refclkdist_pkg::*;

  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW-1:0] ratio_q, ratio_d;
  logic [DIVW-1:0] ratio_fix;
  logic            en_q, en_d;
  logic            pos_hi_q, pos_hi_d;
  logic            neg_hi_q;
  logic            sync_pls_q, sync_pls_d;
  logic            wrap;

  always_comb begin
    ratio_fix  = (ch_ratio < DIVW'(MIN_RATIO)) ? DIVW'(MIN_RATIO) : ch_ratio;
    wrap       = (cnt_q >= (ratio_q - 1'b1));
    cnt_d      = cnt_q + 1'b1;
    ratio_d    = ratio_q;
    en_d       = en_q;
    // Shadows only move at a period boundary so the output never runts.
    if (wrap || sync_rise) begin
      cnt_d   = '0;
      ratio_d = ratio_fix;
      en_d    = ch_en;
    end
    pos_hi_d   = en_d & (cnt_d < (ratio_d >> 1));
    sync_pls_d = en_d & (cnt_d == '0);
  end

  always_ff @(posedge x4clk_in or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q      <= '0;
      ratio_q    <= DIVW'(RST_RATIO);
      en_q       <= 1'b0;
      pos_hi_q   <= 1'b0;
      sync_pls_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ratio_q    <= ratio_d;
      en_q       <= en_d;
      pos_hi_q   <= pos_hi_d;
      sync_pls_q <= sync_pls_d;
    end
  end

  // Half-cycle extension of the high phase for odd ratios.
  always_ff @(negedge x4clk_in or negedge rst_b) begin
    if (!rst_b) begin
      neg_hi_q <= 1'b0;
    end else begin
      neg_hi_q <= pos_hi_q;
    end
  end

  assign ch_clk_out  = pos_hi_q | (neg_hi_q & ratio_q[0]);
  assign ch_sync_out = sync_pls_q;

endmodule

// File: rtl/hqm_rcfwl_gclk_refclkdist_prog.sv
// Reference-clock distributor: shared sync edge detect feeding NUM_CH programmable dividers.
module hqm_rcfwl_gclk_refclkdist_prog #(
  parameter int NUM_CH    = 4,
  parameter int DIVW      = 4,
  parameter int DEF_RATIO = hqm_rcfwl_gclk_refclkdist_pkg::DEF_RATIO
) (
  input  logic                   x4clk_in,
  input  logic                   rst_b,
  input  logic                   sync,
  input  logic [NUM_CH-1:0]      ch_en,
  input  logic [NUM_CH*DIVW-1:0] ch_ratio,
  output logic                   x4clk_out,
  output logic                   sync_out,
  output logic [NUM_CH-1:0]      ch_clk_out,
  output logic [NUM_CH-1:0]      ch_sync_out,
  output logic                   aligned
);
  import hqm_rcfwl_gclk_refclkdist_pkg::*;

  logic sync_q, sync_q2;
  logic aligned_q, aligned_d;
  logic sync_rise;

  always_comb begin
    sync_rise = sync_q & ~sync_q2;
    aligned_d = aligned_q | sync_rise;
  end

  always_ff @(posedge x4clk_in or negedge rst_b) begin
    if (!rst_b) begin
      sync_q    <= 1'b0;
      sync_q2   <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      sync_q    <= sync;
      sync_q2   <= sync_q;
      aligned_q <= aligned_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hqm_rcfwl_gclk_chdiv #(
      .DIVW      (DIVW),
      .RST_RATIO (DEF_RATIO)
    ) u_chdiv (
      .x4clk_in    (x4clk_in),
      .rst_b       (rst_b),
      .sync_rise   (sync_rise),
      .ch_en       (ch_en[g]),
      .ch_ratio    (ch_ratio[g*DIVW +: DIVW]),
      .ch_clk_out  (ch_clk_out[g]),
      .ch_sync_out (ch_sync_out[g])
    );
  end

  assign x4clk_out = x4clk_in;
  assign sync_out  = sync_q;
  assign aligned   = aligned_q;

endmodule

// File: tb/tb_hqm_rcfwl_gclk_refclkdist_prog.sv
// Directed plus random stimulus against a period/phase model of the distributor.
module tb_hqm_rcfwl_gclk_refclkdist_prog;
  localparam int NUM_CH    = 4;
  localparam int DIVW      = 4;
  localparam int DEF_RATIO = 4;

  logic                   clk = 1'b0;
  logic                   rst_b = 1'b0;
  logic                   sync = 1'b0;
  logic [NUM_CH-1:0]      ch_en = '0;
  logic [NUM_CH*DIVW-1:0] ch_ratio = '0;
  logic                   x4clk_out;
  logic                   sync_out;
  logic [NUM_CH-1:0]      ch_clk_out;
  logic [NUM_CH-1:0]      ch_sync_out;
  logic                   aligned;

  hqm_rcfwl_gclk_refclkdist_prog #(
    .NUM_CH    (NUM_CH),
    .DIVW      (DIVW),
    .DEF_RATIO (DEF_RATIO)
  ) dut (
    .x4clk_in    (clk),
    .rst_b       (rst_b),
    .sync        (sync),
    .ch_en       (ch_en),
    .ch_ratio    (ch_ratio),
    .x4clk_out   (x4clk_out),
    .sync_out    (sync_out),
    .ch_clk_out  (ch_clk_out),
    .ch_sync_out (ch_sync_out),
    .aligned     (aligned)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: position within the current period, period length, enable for that period.
  int m_pos [NUM_CH];
  int m_len [NUM_CH];
  bit m_on  [NUM_CH];
  bit m_s1, m_s2, m_al;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pos[c] = 0;
      m_len[c] = DEF_RATIO;
      m_on[c]  = 1'b0;
    end
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    m_al = 1'b0;
  endtask

  task automatic set_ratio(input int c, input int v);
    ch_ratio[c*DIVW +: DIVW] = DIVW'(v);
  endtask

  // Advance one source cycle: model update at posedge, check both half-cycles.
  task automatic step();
    logic [NUM_CH-1:0] e_hi, e_lo, e_sp;
    bit rise;
    int req;
    @(posedge clk);
    rise = m_s1 && !m_s2;
    for (int c = 0; c < NUM_CH; c++) begin
      req = int'(ch_ratio[c*DIVW +: DIVW]);
      if (rise || m_pos[c] >= m_len[c] - 1) begin
        m_pos[c] = 0;
        m_len[c] = (req < 2) ? 2 : req;
        m_on[c]  = ch_en[c];
      end else begin
        m_pos[c]++;
      end
    end
    m_s2 = m_s1;
    m_s1 = sync;
    if (rise) m_al = 1'b1;
    // High for the first len half-cycles of each 2*len half-cycle period.
    for (int c = 0; c < NUM_CH; c++) begin
      e_hi[c] = m_on[c] && (2 * m_pos[c] < m_len[c]);
      e_lo[c] = m_on[c] && (2 * m_pos[c] + 1 < m_len[c]);
      e_sp[c] = m_on[c] && (m_pos[c] == 0);
    end
    #1;
    check("clk_first_half", 32'(ch_clk_out), 32'(e_hi));
    check("ch_sync_out", 32'(ch_sync_out), 32'(e_sp));
    check("aligned", 32'(aligned), 32'(m_al));
    check("sync_out", 32'(sync_out), 32'(m_s1));
    check("x4clk_out_hi", 32'(x4clk_out), 32'd1);
    @(negedge clk);
    #1;
    check("clk_second_half", 32'(ch_clk_out), 32'(e_lo));
    check("x4clk_out_lo", 32'(x4clk_out), 32'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_pos(input int c, input int p);
    for (int i = 0; i < 40; i++) begin
      if (m_pos[c] == p) return;
      step();
    end
    check("reach_phase", 32'(m_pos[c]), 32'(p));
  endtask

  initial begin
    model_reset();
    ch_en = '0;
    set_ratio(0, 2); set_ratio(1, 3); set_ratio(2, 4); set_ratio(3, 5);
    #12;
    check("rst_clk", 32'(ch_clk_out), 32'd0);
    check("rst_sync", 32'(ch_sync_out), 32'd0);
    check("rst_aligned", 32'(aligned), 32'd0);
    check("rst_sync_out", 32'(sync_out), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Enable everything, then a single sync pulse aligns all four channels.
    run(2);
    ch_en = '1;
    run(6);
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    check("all_rise_together", 32'(ch_clk_out), 32'hF);
    check("aligned_after_sync", 32'(aligned), 32'd1);
    run(20);

    // Ratio change mid-period takes effect only at the next wrap.
    set_ratio(0, 4);
    run(6);
    run_until_pos(0, 1);
    set_ratio(0, 6);
    run(16);

    // Sync pulse part way through a 7-cycle period on channel 1.
    set_ratio(1, 7);
    run(8);
    run_until_pos(1, 3);
    sync = 1'b1;
    step();
    sync = 1'b0;
    run(16);

    // Disable channel 2 during its high phase, then re-enable.
    set_ratio(2, 4);
    run(4);
    run_until_pos(2, 0);
    ch_en[2] = 1'b0;
    run(12);
    ch_en[2] = 1'b1;
    run(12);

    // Ratios 0 and 1 divide by 2; long sync gives one realignment.
    set_ratio(3, 0);
    set_ratio(0, 1);
    run(8);
    sync = 1'b1;
    run(20);
    sync = 1'b0;
    run(10);

    // Random ratios and sync pulses with all channels enabled.
    ch_en = '1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) set_ratio($urandom_range(0, NUM_CH - 1), $urandom_range(0, 15));
      sync = ($urandom_range(0, 15) == 0);
      step();
    end
    sync = 1'b0;
    run(4);

    // Random enables and ratios without sync activity.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) ch_en = NUM_CH'($urandom);
      if ($urandom_range(0, 3) == 0) set_ratio($urandom_range(0, NUM_CH - 1), $urandom_range(0, 15));
      step();
    end

    // Asynchronous reset mid-period.
    ch_en = '1;
    set_ratio(0, 6); set_ratio(1, 6); set_ratio(2, 6); set_ratio(3, 6);
    run(16);
    run_until_pos(0, 1);
    #1;
    rst_b = 1'b0;
    #1;
    check("async_rst_clk", 32'(ch_clk_out), 32'd0);
    check("async_rst_sync", 32'(ch_sync_out), 32'd0);
    check("async_rst_aligned", 32'(aligned), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("held_rst_clk", 32'(ch_clk_out), 32'd0);
    rst_b = 1'b1;
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
